// File: rtl/fixed_msa_residual_add_if.sv
// Valid/ready block stream used by the residual-add stage.
// One transfer moves a whole IN_PARALLELISM x IN_SIZE block, flattened row-major.
interface fixed_msa_residual_add_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 12
);

  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] data;
  logic                                 valid;
  logic                                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/fixed_msa_residual_add.sv
// Residual-add stage after multi-head self-attention.
// Residual blocks are queued in a circular FIFO as they enter attention.
// Each attention output block is summed element-wise with the oldest queued
// residual block. The result saturates to DATA_WIDTH and sits in a single
// output register that feeds the normalisation stage.
module fixed_msa_residual_add #(
  parameter int DATA_WIDTH         = 8,
  parameter int DATA_FRAC_WIDTH    = 1,
  parameter int IN_PARALLELISM     = 3,
  parameter int IN_SIZE            = 4,
  parameter int IN_DEPTH           = 3,
  parameter int IN_NUM_PARALLELISM = 2,
  parameter int BUF_DEPTH          = IN_DEPTH * IN_NUM_PARALLELISM
) (
  input  logic                             clk,
  input  logic                             rst,
  fixed_msa_residual_add_if.slave          res_in,
  fixed_msa_residual_add_if.slave          att_in,
  fixed_msa_residual_add_if.master         data_out,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   fifo_count
);

  localparam int NUM_ELEMS   = IN_PARALLELISM * IN_SIZE;
  localparam int PTR_WIDTH   = $clog2(BUF_DEPTH);
  localparam int COUNT_WIDTH = $clog2(BUF_DEPTH + 1);

  localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(BUF_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(BUF_DEPTH);

  typedef logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] block_t;

  // Both operands share one fixed-point format, so the sum needs no alignment
  // shift. A nonsensical fractional width or a one-entry FIFO is rejected at
  // elaboration time.
  if (BUF_DEPTH < 2) begin : g_bad_depth
    $error("fixed_msa_residual_add: BUF_DEPTH must be at least 2");
  end
  if (DATA_FRAC_WIDTH < 0 || DATA_FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
    $error("fixed_msa_residual_add: DATA_FRAC_WIDTH out of range");
  end

  block_t                               mem [BUF_DEPTH];
  logic [PTR_WIDTH-1:0]                 wr_ptr;
  logic [PTR_WIDTH-1:0]                 rd_ptr;
  logic [COUNT_WIDTH-1:0]               count;
  block_t                               head;
  block_t                               sum;
  logic [NUM_ELEMS-1:0][DATA_WIDTH:0]   wide_sum;
  block_t                               out_data;
  logic                                 out_valid;
  logic                                 out_free;
  logic                                 push;
  logic                                 pop;

  // res_in_ready depends only on the registered count. When the FIFO is full,
  // a push is refused even if a pop happens in the same cycle.
  assign res_in.ready = (count != FULL_COUNT);
  assign out_free     = !out_valid || data_out.ready;
  assign att_in.ready = (count != '0) && out_free;

  assign push = res_in.valid && res_in.ready;
  assign pop  = att_in.valid && att_in.ready;

  assign head          = mem[rd_ptr];
  assign fifo_count    = count;
  assign data_out.data = out_data;
  assign data_out.valid = out_valid;

  // Residual payload storage. It has no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res_in.data;
    end
  end

  // Widen each element pair by one bit, add, then clamp to the signed range.
  always_comb begin
    sum      = '0;
    wide_sum = '0;
    for (int e = 0; e < NUM_ELEMS; e++) begin
      wide_sum[e] = {att_in.data[e][DATA_WIDTH-1], att_in.data[e]}
                  + {head[e][DATA_WIDTH-1], head[e]};
      if (wide_sum[e][DATA_WIDTH] != wide_sum[e][DATA_WIDTH-1]) begin
        sum[e] = wide_sum[e][DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        sum[e] = wide_sum[e][DATA_WIDTH-1:0];
      end
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop moves both
  // pointers and leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register. It loads on every accepted attention block, empties after
  // a downstream transfer, and holds while back-pressured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= sum;
      out_valid <= 1'b1;
    end else if (data_out.ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_msa_residual_add.sv
// Self-checking bench for fixed_msa_residual_add.
// A queue-based model predicts occupancy, handshake readiness and every output
// block. Directed phases pin literal results.
module tb_fixed_msa_residual_add;

  localparam int DW   = 8;
  localparam int NE   = 12;
  localparam int BUFD = 6;
  localparam int CW   = 3;

  typedef logic [NE-1:0][DW-1:0] blk_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] fifo_count;

  fixed_msa_residual_add_if #(.DATA_WIDTH(DW), .NUM_ELEMS(NE)) res_bus ();
  fixed_msa_residual_add_if #(.DATA_WIDTH(DW), .NUM_ELEMS(NE)) att_bus ();
  fixed_msa_residual_add_if #(.DATA_WIDTH(DW), .NUM_ELEMS(NE)) out_bus ();

  fixed_msa_residual_add #(
    .DATA_WIDTH(DW), .DATA_FRAC_WIDTH(1), .IN_PARALLELISM(3), .IN_SIZE(4),
    .IN_DEPTH(3), .IN_NUM_PARALLELISM(2), .BUF_DEPTH(BUFD)
  ) dut (
    .clk(clk), .rst(rst),
    .res_in(res_bus.slave), .att_in(att_bus.slave), .data_out(out_bus.master),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   out_xfers = 0;
  blk_t res_q[$];
  blk_t exp_q[$];
  blk_t head_blk;
  logic exp_valid;
  logic stream_done = 1'b0;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic blk_t fill(input logic [DW-1:0] v);
    blk_t b;
    for (int e = 0; e < NE; e++) b[e] = v;
    return b;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int e = 0; e < NE; e++) b[e] = DW'($urandom);
    return b;
  endfunction

  function automatic blk_t sat_add(input blk_t a, input blk_t b);
    blk_t r;
    int   s;
    for (int e = 0; e < NE; e++) begin
      s = int'($signed(a[e])) + int'($signed(b[e]));
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      r[e] = DW'(s);
    end
    return r;
  endfunction

  // Reference model and compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      check_output("reset_valid", out_bus.valid, 0);
      check_output("reset_count", fifo_count, 0);
      check_output("reset_data", out_bus.data, 0);
      res_q.delete();
      exp_q.delete();
    end else begin
      exp_valid = (exp_q.size() != 0);
      check_output("out_valid", out_bus.valid, exp_valid);
      if (exp_valid) check_output("out_data", out_bus.data, exp_q[0]);
      check_output("fifo_count", fifo_count, res_q.size());
      check_output("res_ready", res_bus.ready, res_q.size() != BUFD);
      check_output("att_ready", att_bus.ready,
                   (res_q.size() != 0) && (!exp_valid || out_bus.ready));
      if (out_bus.valid && out_bus.ready) begin
        out_xfers++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (att_bus.valid && att_bus.ready && res_q.size() != 0) begin
        head_blk = res_q.pop_front();
        exp_q.push_back(sat_add(att_bus.data, head_blk));
      end
      if (res_bus.valid && res_bus.ready) res_q.push_back(res_bus.data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_res(input blk_t b);
    int n = 0;
    res_bus.data  = b;
    res_bus.valid = 1'b1;
    @(negedge clk);
    while (!res_bus.ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check_output("res_timeout", 1, 0);
    step();
    res_bus.valid = 1'b0;
  endtask

  task automatic apply_att(input blk_t b);
    int n = 0;
    att_bus.data  = b;
    att_bus.valid = 1'b1;
    @(negedge clk);
    while (!att_bus.ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check_output("att_timeout", 1, 0);
    step();
    att_bus.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    blk_t sat_res [3];
    blk_t sat_att [3];
    blk_t sat_exp [3];
    int   base;

    res_bus.valid = 1'b0; res_bus.data = '0;
    att_bus.valid = 1'b0; att_bus.data = '0;
    out_bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    step();

    // Basic add: 1.5 + (-2.5) = -1.0, which is 0xFE in Q6.1
    apply_res(fill(8'd3));
    apply_att(fill(8'hFB));
    @(negedge clk);
    check_output("basic_valid", out_bus.valid, 1);
    check_output("basic_sum", out_bus.data, fill(8'hFE));
    step();
    @(negedge clk);
    check_output("basic_count", fifo_count, 0);
    step();

    // Saturation corners
    sat_res[0] = fill(8'd100);  sat_att[0] = fill(8'd100);  sat_exp[0] = fill(8'h7F);
    sat_res[1] = fill(8'h9C);   sat_att[1] = fill(8'h9C);   sat_exp[1] = fill(8'h80);
    sat_res[2] = fill(8'h7F);   sat_att[2] = fill(8'h00);   sat_exp[2] = fill(8'h7F);
    for (int i = 0; i < 3; i++) begin
      apply_res(sat_res[i]);
      apply_att(sat_att[i]);
      @(negedge clk);
      check_output("sat_sum", out_bus.data, sat_exp[i]);
      step();
    end

    // Fill the FIFO, then try to overfill it
    for (int i = 0; i < BUFD; i++) apply_res(rand_blk());
    @(negedge clk);
    check_output("full_count", fifo_count, 6);
    check_output("full_res_ready", res_bus.ready, 0);
    step();
    res_bus.data = rand_blk();
    res_bus.valid = 1'b1;
    step();
    att_bus.data = rand_blk();
    att_bus.valid = 1'b1;
    @(negedge clk);
    check_output("full_pop_ready", att_bus.ready, 1);
    check_output("full_push_refused", res_bus.ready, 0);
    step();
    att_bus.valid = 1'b0;
    res_bus.valid = 1'b0;
    @(negedge clk);
    check_output("after_full_pop", fifo_count, 5);
    step();

    // Concurrent push and pop at count 3
    apply_att(rand_blk());
    apply_att(rand_blk());
    res_bus.data = rand_blk();
    att_bus.data = rand_blk();
    res_bus.valid = 1'b1;
    att_bus.valid = 1'b1;
    @(negedge clk);
    check_output("conc_count_before", fifo_count, 3);
    check_output("conc_both_ready", {res_bus.ready, att_bus.ready}, 2'b11);
    step();
    res_bus.valid = 1'b0;
    att_bus.valid = 1'b0;
    @(negedge clk);
    check_output("conc_count_after", fifo_count, 3);
    step();

    // Drain the FIFO, then stall att_in on an empty FIFO
    for (int i = 0; i < 3; i++) apply_att(rand_blk());
    att_bus.data = rand_blk();
    att_bus.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("empty_stall", att_bus.ready, 0);
      step();
    end
    res_bus.data = rand_blk();
    res_bus.valid = 1'b1;
    @(negedge clk);
    check_output("stall_push_cycle", att_bus.ready, 0);
    step();
    res_bus.valid = 1'b0;
    @(negedge clk);
    check_output("stall_release", att_bus.ready, 1);
    step();
    att_bus.valid = 1'b0;
    step();

    // Tagged random stream with random back-pressure
    base = out_xfers;
    fork
      begin
        while (!stream_done) begin
          step();
          out_bus.ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          blk_t b;
          b = rand_blk();
          b[0] = DW'(k);
          repeat ($urandom_range(0, 2)) step();
          apply_res(b);
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          blk_t b;
          b = rand_blk();
          b[0] = DW'(k);
          repeat ($urandom_range(0, 3)) step();
          apply_att(b);
        end
      end
    join
    stream_done = 1'b1;
    step();
    out_bus.ready = 1'b1;
    repeat (3) step();
    check_output("stream_out_count", out_xfers - base, 12);

    // Reset while blocks are buffered and an output is pending
    out_bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) apply_res(rand_blk());
    apply_att(rand_blk());
    @(negedge clk);
    check_output("pre_reset_count", fifo_count, 4);
    check_output("pre_reset_valid", out_bus.valid, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_valid", out_bus.valid, 0);
    check_output("async_reset_count", fifo_count, 0);
    out_bus.ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step();
    apply_res(fill(8'h10));
    apply_att(fill(8'h05));
    @(negedge clk);
    check_output("post_reset_sum", out_bus.data, fill(8'h15));
    step();
    apply_res(rand_blk());
    apply_att(rand_blk());
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
